// File: rtl/mas_alu_req_ctrl_pkg.sv
// Shared types for the ALU request controller: command encoding, FIFO entry
// layout and the request FSM state encoding.
`ifndef MAS_BLEN
`define MAS_BLEN 32
`endif

package mas_alu_req_ctrl_pkg;

    // ALU operation codes; ADD is the reset value of the command output.
    typedef enum logic [2:0] {
        MAS_ALU_ADD = 3'd0,
        MAS_ALU_SUB = 3'd1,
        MAS_ALU_AND = 3'd2,
        MAS_ALU_OR  = 3'd3,
        MAS_ALU_XOR = 3'd4
    } type_mas_alu_cmd;

    // Request FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } type_mas_alu_req_state;

    // One queued command as stored in the command FIFO.
    typedef struct packed {
        type_mas_alu_cmd       cmd;
        logic [`MAS_BLEN-1:0]  op1;
        logic [`MAS_BLEN-1:0]  op2;
    } type_mas_alu_req_entry;

endpackage

// File: rtl/mas_alu_cmd_fifo.sv
// Small synchronous command FIFO with a registered occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module mas_alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             not_full
);

    localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign not_full = (count < DEPTH_C);
    assign empty    = (count == '0);
    assign do_push  = push && not_full;
    assign do_pop   = pop && !empty;
    assign rdata    = mem[rd_ptr];

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count as is.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mas_alu_req_ctrl.sv
// ALU request controller: queues commands, issues them one at a time to the
// ALU, waits for the result strobe with a timeout, and holds the result
// until downstream accepts it.
`ifndef MAS_BLEN
`define MAS_BLEN 32
`endif

module mas_alu_req_ctrl
    import mas_alu_req_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  type_mas_alu_cmd      in_cmd,
    input  logic [`MAS_BLEN-1:0] in_op1,
    input  logic [`MAS_BLEN-1:0] in_op2,
    output logic                 mas_alu_req,
    output type_mas_alu_cmd      mas_alu_cmd,
    output logic [`MAS_BLEN-1:0] mas_alu_op1,
    output logic [`MAS_BLEN-1:0] mas_alu_op2,
    input  logic                 mas_alu_ready,
    input  logic [`MAS_BLEN-1:0] mas_alu_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [`MAS_BLEN-1:0] out_res,
    output logic                 out_err,
    output logic                 busy
);

    localparam int ENTRY_W = $bits(type_mas_alu_req_entry);
    localparam int WCNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(TIMEOUT);

    type_mas_alu_req_state state;
    type_mas_alu_req_state state_nx;
    type_mas_alu_req_entry push_entry;
    type_mas_alu_req_entry head;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic                  fifo_not_full;
    logic [WCNT_W-1:0]     wait_cnt;
    logic                  timeout_hit;

    // Upstream is held off during reset so nothing is queued under rst.
    assign in_ready    = fifo_not_full && !rst;
    assign fifo_push   = in_valid && in_ready;
    assign push_entry  = '{cmd: in_cmd, op1: in_op1, op2: in_op2};
    assign timeout_hit = (wait_cnt == TIMEOUT_C);

    assign mas_alu_req = (state == ST_ISSUE);
    assign out_valid   = (state == ST_RESP);
    assign busy        = (state != ST_IDLE) || !fifo_empty;

    mas_alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .wdata    (push_entry),
        .pop      (fifo_pop),
        .rdata    (head),
        .empty    (fifo_empty),
        .not_full (fifo_not_full)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and FIFO pop; a result strobe wins over a coincident timeout.
    always_comb begin
        state_nx = state;
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mas_alu_ready || timeout_hit) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Issue registers, wait counter and captured result; strobes outside ISSUE are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            mas_alu_cmd <= MAS_ALU_ADD;
            mas_alu_op1 <= '0;
            mas_alu_op2 <= '0;
            out_res     <= '0;
            out_err     <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        mas_alu_cmd <= head.cmd;
                        mas_alu_op1 <= head.op1;
                        mas_alu_op2 <= head.op2;
                        wait_cnt    <= '0;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= wait_cnt + WCNT_W'(1);
                    if (mas_alu_ready) begin
                        out_res <= mas_alu_res;
                        out_err <= 1'b0;
                    end else if (timeout_hit) begin
                        out_res <= '0;
                        out_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mas_alu_req_ctrl.sv
// Directed testbench for mas_alu_req_ctrl with a simple ALU responder model.
`ifndef MAS_BLEN
`define MAS_BLEN 32
`endif

module tb_mas_alu_req_ctrl;
    import mas_alu_req_ctrl_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 10;
    localparam int BW      = `MAS_BLEN;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    type_mas_alu_cmd in_cmd = MAS_ALU_ADD;
    logic [BW-1:0]   in_op1 = '0;
    logic [BW-1:0]   in_op2 = '0;
    logic            mas_alu_req;
    type_mas_alu_cmd mas_alu_cmd;
    logic [BW-1:0]   mas_alu_op1;
    logic [BW-1:0]   mas_alu_op2;
    logic            mas_alu_ready;
    logic [BW-1:0]   mas_alu_res;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BW-1:0]   out_res;
    logic            out_err;
    logic            busy;

    int   checks = 0;
    int   errors = 0;
    logic alu_en = 1'b0;
    int   alu_delay = 0;
    logic force_ready = 1'b0;
    int   req_cyc;

    mas_alu_req_ctrl #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_cmd        (in_cmd),
        .in_op1        (in_op1),
        .in_op2        (in_op2),
        .mas_alu_req   (mas_alu_req),
        .mas_alu_cmd   (mas_alu_cmd),
        .mas_alu_op1   (mas_alu_op1),
        .mas_alu_op2   (mas_alu_op2),
        .mas_alu_ready (mas_alu_ready),
        .mas_alu_res   (mas_alu_res),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_res       (out_res),
        .out_err       (out_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] alu_model(type_mas_alu_cmd c, logic [BW-1:0] a, logic [BW-1:0] b);
        case (c)
            MAS_ALU_ADD: return a + b;
            MAS_ALU_SUB: return a - b;
            MAS_ALU_AND: return a & b;
            MAS_ALU_OR:  return a | b;
            MAS_ALU_XOR: return a ^ b;
            default:     return '0;
        endcase
    endfunction

    // ALU responder: strobes ready alu_delay cycles after req rises.
    always @(posedge clk) req_cyc <= mas_alu_req ? req_cyc + 1 : 0;
    assign mas_alu_ready = (mas_alu_req && alu_en && (req_cyc == alu_delay)) || force_ready;
    assign mas_alu_res   = alu_model(mas_alu_cmd, mas_alu_op1, mas_alu_op2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input type_mas_alu_cmd c, input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1; in_cmd = c; in_op1 = a; in_op2 = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL push_accept got %b expected 1", ok); end
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b expected 0", in_ready); end
        checks++; if (mas_alu_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b expected 0", mas_alu_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
        checks++; if (mas_alu_cmd !== MAS_ALU_ADD) begin errors++; $display("FAIL rst_cmd got %0d expected 0", mas_alu_cmd); end
        checks++; if (mas_alu_op1 !== '0 || mas_alu_op2 !== '0) begin errors++; $display("FAIL rst_ops got %0h/%0h expected 0/0", mas_alu_op1, mas_alu_op2); end
        checks++; if (out_res !== '0 || out_err !== 1'b0) begin errors++; $display("FAIL rst_result got %0h/%b expected 0/0", out_res, out_err); end
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b expected 1", in_ready); end
    endtask

    task automatic test_idle_ready();
        force_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || mas_alu_req !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL idle_ready valid/req/busy got %b%b%b expected 000", out_valid, mas_alu_req, busy);
            end
        end
        force_ready = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic prev, got;
        int   episodes, req_n;
        alu_en = 1'b1; alu_delay = 2; out_ready = 1'b0;
        push_cmd(MAS_ALU_ADD, BW'(5), BW'(3));
        prev = 1'b0; got = 1'b0; episodes = 0; req_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (mas_alu_req === 1'b1 && !prev) episodes++;
            if (mas_alu_req === 1'b1) req_n++;
            prev = mas_alu_req;
            if (out_valid === 1'b1) begin got = 1'b1; break; end
            tick();
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL single_valid got %b expected 1", got); end
        checks++; if (episodes != 1) begin errors++; $display("FAIL single_episodes got %0d expected 1", episodes); end
        checks++; if (req_n != 3) begin errors++; $display("FAIL single_req_cycles got %0d expected 3", req_n); end
        checks++; if (out_res !== BW'(8)) begin errors++; $display("FAIL single_res got %0h expected 8", out_res); end
        checks++; if (out_err !== 1'b0 || mas_alu_req !== 1'b0) begin errors++; $display("FAIL single_err_req got %b/%b expected 0/0", out_err, mas_alu_req); end
        accept_result();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done valid/busy got %b/%b expected 0/0", out_valid, busy); end
    endtask

    task automatic test_min_latency();
        alu_en = 1'b1; alu_delay = 0;
        push_cmd(MAS_ALU_OR, BW'(1), BW'(2));
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL lat_push valid/busy got %b/%b expected 0/1", out_valid, busy); end
        tick();
        checks++; if (mas_alu_req !== 1'b1 || mas_alu_cmd !== MAS_ALU_OR || mas_alu_op1 !== BW'(1)) begin
            errors++; $display("FAIL lat_issue req/cmd/op1 got %b/%0d/%0h expected 1/3/1", mas_alu_req, mas_alu_cmd, mas_alu_op1);
        end
        tick();
        checks++; if (out_valid !== 1'b1 || out_res !== BW'(3)) begin errors++; $display("FAIL lat_resp valid/res got %b/%0h expected 1/3", out_valid, out_res); end
        accept_result();
    endtask

    task automatic test_back_to_back();
        type_mas_alu_cmd c [5];
        logic [BW-1:0]   a [5];
        logic [BW-1:0]   b [5];
        logic [BW-1:0]   e [5];
        logic            ok;
        c[0] = MAS_ALU_ADD; a[0] = BW'('h000A); b[0] = BW'('h0014); e[0] = BW'('h001E);
        c[1] = MAS_ALU_SUB; a[1] = BW'('h0032); b[1] = BW'('h0008); e[1] = BW'('h002A);
        c[2] = MAS_ALU_AND; a[2] = BW'('hF0F0); b[2] = BW'('h0FF0); e[2] = BW'('h00F0);
        c[3] = MAS_ALU_OR;  a[3] = BW'('h1200); b[3] = BW'('h0034); e[3] = BW'('h1234);
        c[4] = MAS_ALU_XOR; a[4] = BW'('hFF00); b[4] = BW'('h0FF0); e[4] = BW'('hF0F0);
        alu_en = 1'b1; alu_delay = 0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(c[i], a[i], b[i]);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full in_ready got %b expected 0", in_ready); end
        tick(); tick(); tick();
        checks++; if (in_ready !== 1'b0 || mas_alu_req !== 1'b0) begin errors++; $display("FAIL b2b_hold in_ready/req got %b/%b expected 0/0", in_ready, mas_alu_req); end
        wait_valid(ok);
        checks++; if (ok !== 1'b1 || out_res !== e[0]) begin errors++; $display("FAIL b2b_res0 got %0h expected %0h", out_res, e[0]); end
        accept_result();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_prepop in_ready got %b expected 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_afterpop in_ready got %b expected 1", in_ready); end
        for (int i = 1; i < 5; i++) begin
            wait_valid(ok);
            checks++;
            if (ok !== 1'b1 || out_res !== e[i] || out_err !== 1'b0) begin
                errors++; $display("FAIL b2b_res%0d got %0h/%b expected %0h/0", i, out_res, out_err, e[i]);
            end
            accept_result();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy got %b expected 0", busy); end
    endtask

    task automatic test_timeout_and_stall();
        logic ok;
        int   n;
        alu_en = 1'b0; out_ready = 1'b0;
        push_cmd(MAS_ALU_SUB, BW'(9), BW'(4));
        for (int i = 0; i < 10 && mas_alu_req !== 1'b1; i++) tick();
        n = 0;
        while (mas_alu_req === 1'b1 && n < 50) begin n++; tick(); end
        checks++; if (n != TIMEOUT + 1) begin errors++; $display("FAIL tmo_issue_cycles got %0d expected %0d", n, TIMEOUT + 1); end
        checks++; if (out_valid !== 1'b1 || out_res !== '0 || out_err !== 1'b1) begin
            errors++; $display("FAIL tmo_result valid/res/err got %b/%0h/%b expected 1/0/1", out_valid, out_res, out_err);
        end
        push_cmd(MAS_ALU_XOR, BW'(6), BW'(3));
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_res !== '0 || out_err !== 1'b1 || mas_alu_req !== 1'b0) begin
                errors++; $display("FAIL stall_c%0d valid/res/err/req got %b/%0h/%b/%b expected 1/0/1/0", i, out_valid, out_res, out_err, mas_alu_req);
            end
        end
        alu_en = 1'b1; alu_delay = 1;
        accept_result();
        wait_valid(ok);
        checks++; if (ok !== 1'b1 || out_res !== BW'(5) || out_err !== 1'b0) begin
            errors++; $display("FAIL tmo_next got %b/%0h/%b expected 1/5/0", ok, out_res, out_err);
        end
        accept_result();
    endtask

    task automatic test_reset_in_issue();
        logic seen_valid, seen_req;
        alu_en = 1'b0; out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_cmd(MAS_ALU_ADD, BW'(i), BW'(i));
        checks++; if (mas_alu_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rstiss_pre req/busy got %b/%b expected 1/1", mas_alu_req, busy); end
        rst = 1'b1;
        tick();
        checks++; if (mas_alu_req !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstiss_post req/valid/busy got %b/%b/%b expected 0/0/0", mas_alu_req, out_valid, busy);
        end
        rst = 1'b0; alu_en = 1'b1; alu_delay = 0; out_ready = 1'b1;
        seen_valid = 1'b0; seen_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid === 1'b1) seen_valid = 1'b1;
            if (mas_alu_req === 1'b1) seen_req = 1'b1;
        end
        out_ready = 1'b0;
        checks++; if (seen_valid !== 1'b0 || seen_req !== 1'b0) begin
            errors++; $display("FAIL rstiss_flush valid/req seen %b/%b expected 0/0", seen_valid, seen_req);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ready();
        test_single();
        test_min_latency();
        test_back_to_back();
        test_timeout_and_stall();
        test_reset_in_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
